// File: rtl/ex_alu_pipe_if.sv
// ex_alu_pipe_if: bundles every EX-stage input coming from ID/EX and every
// EX/MEM output heading to the MEM stage. The producer side (ID/EX model or
// testbench) uses the master modport, the execute stage uses slave.
interface ex_alu_pipe_if;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] rt_data;
    logic [31:0] pc_in;
    logic [4:0]  wb_dest_in;
    logic        RegWrite_in;
    logic        MemWrite_in;
    logic        MemRead_in;
    logic        MemToReg_in;
    logic        branch_in;
    logic [1:0]  load_mode_in;

    logic [3:0]  alu_ctrl;
    logic        RegWrite_out;
    logic        MemWrite_out;
    logic        MemRead_out;
    logic        MemToReg_out;
    logic        branch_out;
    logic [1:0]  load_mode_out;
    logic [31:0] pc_out;
    logic        zero_out;
    logic [31:0] aluResult_out;
    logic [31:0] rt_out;
    logic [4:0]  writebackDestination_out;

    modport master (
        output alu_op, funct, shamt, operand_a, operand_b, rt_data, pc_in,
               wb_dest_in, RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in,
               branch_in, load_mode_in,
        input  alu_ctrl, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out,
               branch_out, load_mode_out, pc_out, zero_out, aluResult_out,
               rt_out, writebackDestination_out
    );

    modport slave (
        input  alu_op, funct, shamt, operand_a, operand_b, rt_data, pc_in,
               wb_dest_in, RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in,
               branch_in, load_mode_in,
        output alu_ctrl, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out,
               branch_out, load_mode_out, pc_out, zero_out, aluResult_out,
               rt_out, writebackDestination_out
    );
endinterface

// File: rtl/ex_alu_pipe.sv
// ex_alu_pipe: execute stage of the 5-stage MIPS pipeline. Decodes ALUOp and
// funct into a 4-bit ALU control code, runs the 32-bit ALU, and captures the
// result, zero flag, control bits and forwarded data into the EX/MEM register.
module ex_alu_pipe (
    input  logic         clk,
    input  logic         reset,
    ex_alu_pipe_if.slave bus
);

    typedef enum logic [3:0] {
        CTRL_AND  = 4'b0000,
        CTRL_OR   = 4'b0001,
        CTRL_ADD  = 4'b0010,
        CTRL_XOR  = 4'b0011,
        CTRL_SUB  = 4'b0110,
        CTRL_SLT  = 4'b0111,
        CTRL_SLL  = 4'b1000,
        CTRL_SRL  = 4'b1001,
        CTRL_SLTU = 4'b1010,
        CTRL_SRA  = 4'b1011,
        CTRL_NOR  = 4'b1100
    } aluCtrl_e;

    aluCtrl_e    w_aluCtrl;
    logic [31:0] w_aluResult;
    logic        w_zero;

    logic [31:0] r_aluResult;
    logic        r_zero;
    logic        r_regWrite;
    logic        r_memWrite;
    logic        r_memRead;
    logic        r_memToReg;
    logic        r_branch;
    logic [1:0]  r_loadMode;
    logic [31:0] r_pc;
    logic [31:0] r_rt;
    logic [4:0]  r_wbDest;

    // ALU control decode: ALUOp picks the operation directly except for
    // R-type, where funct chooses; unrecognised funct values fall back to ADD.
    always_comb begin
        w_aluCtrl = CTRL_ADD;
        case (bus.alu_op)
            3'b000:  w_aluCtrl = CTRL_ADD;
            3'b001:  w_aluCtrl = CTRL_SUB;
            3'b010: begin
                case (bus.funct)
                    6'b100000, 6'b100001: w_aluCtrl = CTRL_ADD;
                    6'b100010, 6'b100011: w_aluCtrl = CTRL_SUB;
                    6'b100100:            w_aluCtrl = CTRL_AND;
                    6'b100101:            w_aluCtrl = CTRL_OR;
                    6'b100110:            w_aluCtrl = CTRL_XOR;
                    6'b100111:            w_aluCtrl = CTRL_NOR;
                    6'b101010:            w_aluCtrl = CTRL_SLT;
                    6'b101011:            w_aluCtrl = CTRL_SLTU;
                    6'b000000:            w_aluCtrl = CTRL_SLL;
                    6'b000010:            w_aluCtrl = CTRL_SRL;
                    6'b000011:            w_aluCtrl = CTRL_SRA;
                    default:              w_aluCtrl = CTRL_ADD;
                endcase
            end
            3'b011:  w_aluCtrl = CTRL_AND;
            3'b100:  w_aluCtrl = CTRL_OR;
            3'b101:  w_aluCtrl = CTRL_SLT;
            3'b110:  w_aluCtrl = CTRL_SLTU;
            default: w_aluCtrl = CTRL_ADD;
        endcase
    end

    assign bus.alu_ctrl = w_aluCtrl;

    // ALU datapath: arithmetic wraps modulo 2^32, shifts act on operand_b by
    // shamt, and any code outside the defined set yields zero.
    always_comb begin
        w_aluResult = 32'd0;
        case (w_aluCtrl)
            CTRL_AND:  w_aluResult = bus.operand_a & bus.operand_b;
            CTRL_OR:   w_aluResult = bus.operand_a | bus.operand_b;
            CTRL_ADD:  w_aluResult = bus.operand_a + bus.operand_b;
            CTRL_XOR:  w_aluResult = bus.operand_a ^ bus.operand_b;
            CTRL_SUB:  w_aluResult = bus.operand_a - bus.operand_b;
            CTRL_SLT:  w_aluResult = ($signed(bus.operand_a) < $signed(bus.operand_b)) ? 32'd1 : 32'd0;
            CTRL_SLTU: w_aluResult = (bus.operand_a < bus.operand_b) ? 32'd1 : 32'd0;
            CTRL_SLL:  w_aluResult = bus.operand_b << bus.shamt;
            CTRL_SRL:  w_aluResult = bus.operand_b >> bus.shamt;
            CTRL_SRA:  w_aluResult = $unsigned($signed(bus.operand_b) >>> bus.shamt);
            CTRL_NOR:  w_aluResult = ~(bus.operand_a | bus.operand_b);
            default:   w_aluResult = 32'd0;
        endcase
    end

    assign w_zero = (w_aluResult == 32'd0);

    // EX/MEM pipeline register: loads every cycle with no stall, and reset
    // clears it asynchronously so the MEM stage sees a bubble immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aluResult <= 32'd0;
            r_zero      <= 1'b0;
            r_regWrite  <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memRead   <= 1'b0;
            r_memToReg  <= 1'b0;
            r_branch    <= 1'b0;
            r_loadMode  <= 2'b00;
            r_pc        <= 32'd0;
            r_rt        <= 32'd0;
            r_wbDest    <= 5'd0;
        end else begin
            r_aluResult <= w_aluResult;
            r_zero      <= w_zero;
            r_regWrite  <= bus.RegWrite_in;
            r_memWrite  <= bus.MemWrite_in;
            r_memRead   <= bus.MemRead_in;
            r_memToReg  <= bus.MemToReg_in;
            r_branch    <= bus.branch_in;
            r_loadMode  <= bus.load_mode_in;
            r_pc        <= bus.pc_in;
            r_rt        <= bus.rt_data;
            r_wbDest    <= bus.wb_dest_in;
        end
    end

    assign bus.aluResult_out            = r_aluResult;
    assign bus.zero_out                 = r_zero;
    assign bus.RegWrite_out             = r_regWrite;
    assign bus.MemWrite_out             = r_memWrite;
    assign bus.MemRead_out              = r_memRead;
    assign bus.MemToReg_out             = r_memToReg;
    assign bus.branch_out               = r_branch;
    assign bus.load_mode_out            = r_loadMode;
    assign bus.pc_out                   = r_pc;
    assign bus.rt_out                   = r_rt;
    assign bus.writebackDestination_out = r_wbDest;

endmodule

// File: tb/tb_ex_alu_pipe.sv
// tb_ex_alu_pipe: directed scoreboard bench for the execute stage. Each step
// drives one instruction, checks the combinational ALU control code, and
// queues the expected EX/MEM contents, which are compared one edge later.
module tb_ex_alu_pipe;

    logic clk;
    logic reset;

    ex_alu_pipe_if bus ();

    ex_alu_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] pc;
        logic [31:0] rt;
        logic [4:0]  wb;
        logic [4:0]  ctl;
        logic [1:0]  lm;
    } expect_t;

    expect_t scoreboard[$];
    int errorCount = 0;
    int checkCount = 0;

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench funnels through here.
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, check the decode right away, queue the EX/MEM image.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] rt, input logic [31:0] pc, input logic [4:0] wb,
                                 input logic [4:0] ctl, input logic [1:0] lm,
                                 input logic [31:0] expRes, input logic [3:0] expCtrl);
        expect_t e;
        bus.alu_op       = op;
        bus.funct        = fn;
        bus.shamt        = sh;
        bus.operand_a    = a;
        bus.operand_b    = b;
        bus.rt_data      = rt;
        bus.pc_in        = pc;
        bus.wb_dest_in   = wb;
        {bus.RegWrite_in, bus.MemWrite_in, bus.MemRead_in, bus.MemToReg_in, bus.branch_in} = ctl;
        bus.load_mode_in = lm;
        #1;
        check32({tag, ".alu_ctrl"}, {28'd0, bus.alu_ctrl}, {28'd0, expCtrl});
        e.res = expRes;
        e.pc  = pc;
        e.rt  = rt;
        e.wb  = wb;
        e.ctl = ctl;
        e.lm  = lm;
        scoreboard.push_back(e);
    endtask

    // Wait for the capturing edge, then compare the registered outputs.
    task automatic checkOutput(input string tag);
        expect_t e;
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checkCount++;
            errorCount++;
            $error("[TB] FAIL %s.scoreboard: observed=empty expected=entry", tag);
            return;
        end
        e = scoreboard.pop_front();
        check32({tag, ".result"}, bus.aluResult_out, e.res);
        check32({tag, ".zero"}, {31'd0, bus.zero_out}, {31'd0, (e.res == 32'd0)});
        check32({tag, ".pc"}, bus.pc_out, e.pc);
        check32({tag, ".rt"}, bus.rt_out, e.rt);
        check32({tag, ".wbDest"}, {27'd0, bus.writebackDestination_out}, {27'd0, e.wb});
        check32({tag, ".ctlBits"},
                {27'd0, bus.RegWrite_out, bus.MemWrite_out, bus.MemRead_out, bus.MemToReg_out, bus.branch_out},
                {27'd0, e.ctl});
        check32({tag, ".loadMode"}, {30'd0, bus.load_mode_out}, {30'd0, e.lm});
    endtask

    // Every registered output must read zero while reset is in effect.
    task automatic checkZeroOutputs(input string tag);
        check32({tag, ".result"}, bus.aluResult_out, 32'd0);
        check32({tag, ".zero"}, {31'd0, bus.zero_out}, 32'd0);
        check32({tag, ".pc"}, bus.pc_out, 32'd0);
        check32({tag, ".rt"}, bus.rt_out, 32'd0);
        check32({tag, ".wbDest"}, {27'd0, bus.writebackDestination_out}, 32'd0);
        check32({tag, ".ctlBits"},
                {27'd0, bus.RegWrite_out, bus.MemWrite_out, bus.MemRead_out, bus.MemToReg_out, bus.branch_out},
                32'd0);
        check32({tag, ".loadMode"}, {30'd0, bus.load_mode_out}, 32'd0);
    endtask

    // Directed sequence: reset, mid-operation reset, decode, shifts, branch, load path.
    initial begin
        reset            = 1'b1;
        bus.alu_op       = 3'd0;
        bus.funct        = 6'd0;
        bus.shamt        = 5'd0;
        bus.operand_a    = 32'd0;
        bus.operand_b    = 32'd0;
        bus.rt_data      = 32'd0;
        bus.pc_in        = 32'd0;
        bus.wb_dest_in   = 5'd0;
        bus.RegWrite_in  = 1'b0;
        bus.MemWrite_in  = 1'b0;
        bus.MemRead_in   = 1'b0;
        bus.MemToReg_in  = 1'b0;
        bus.branch_in    = 1'b0;
        bus.load_mode_in = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        checkZeroOutputs("powerOnReset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] load 0x1234 then reset between edges");
        applyStimulus("preReset", 3'b000, 6'd0, 5'd0, 32'h0000_1000, 32'h0000_0234,
                      32'h1111_2222, 32'h0000_0010, 5'd4, 5'b10000, 2'b01, 32'h0000_1234, 4'b0010);
        checkOutput("preReset");
        #2;
        reset = 1'b1;
        #1;
        checkZeroOutputs("midReset");
        @(posedge clk);
        #1;
        checkZeroOutputs("resetHold");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] logical immediates");
        applyStimulus("andi", 3'b011, 6'd0, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0,
                      32'h0000_0000, 32'h0000_0020, 5'd3, 5'b10000, 2'b00, 32'h0000_00F0, 4'b0000);
        checkOutput("andi");
        applyStimulus("ori", 3'b100, 6'd0, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0,
                      32'h0000_0001, 32'h0000_0024, 5'd5, 5'b10000, 2'b00, 32'h0000_FFF0, 4'b0001);
        checkOutput("ori");

        $display("[TB] R-type decode");
        applyStimulus("sub", 3'b010, 6'b100010, 5'd0, 32'd5, 32'd7,
                      32'h0, 32'h0, 5'd8, 5'b10000, 2'b00, 32'hFFFF_FFFE, 4'b0110);
        checkOutput("sub");
        applyStimulus("slt", 3'b010, 6'b101010, 5'd0, 32'd5, 32'd7,
                      32'h0, 32'h0, 5'd8, 5'b10000, 2'b00, 32'd1, 4'b0111);
        checkOutput("slt");
        applyStimulus("sltu", 3'b010, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1,
                      32'h0, 32'h0, 5'd8, 5'b10000, 2'b00, 32'd0, 4'b1010);
        checkOutput("sltu");
        applyStimulus("xor", 3'b010, 6'b100110, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0,
                      32'h0, 32'h0, 5'd9, 5'b10000, 2'b00, 32'h0000_FF00, 4'b0011);
        checkOutput("xor");
        applyStimulus("nor", 3'b010, 6'b100111, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0,
                      32'h0, 32'h0, 5'd9, 5'b10000, 2'b00, 32'hFFFF_000F, 4'b1100);
        checkOutput("nor");
        applyStimulus("unknownFunct", 3'b010, 6'b111111, 5'd0, 32'd2, 32'd3,
                      32'h0, 32'h0, 5'd10, 5'b10000, 2'b00, 32'd5, 4'b0010);
        checkOutput("unknownFunct");

        $display("[TB] shifts");
        applyStimulus("sll31", 3'b010, 6'b000000, 5'd31, 32'hFFFF_FFFF, 32'd1,
                      32'h0, 32'h0, 5'd11, 5'b10000, 2'b00, 32'h8000_0000, 4'b1000);
        checkOutput("sll31");
        applyStimulus("sll0", 3'b010, 6'b000000, 5'd0, 32'h0, 32'h1234_5678,
                      32'h0, 32'h0, 5'd11, 5'b10000, 2'b00, 32'h1234_5678, 4'b1000);
        checkOutput("sll0");
        applyStimulus("sra4", 3'b010, 6'b000011, 5'd4, 32'h0, 32'h8000_0000,
                      32'h0, 32'h0, 5'd12, 5'b10000, 2'b00, 32'hF800_0000, 4'b1011);
        checkOutput("sra4");
        applyStimulus("srl4", 3'b010, 6'b000010, 5'd4, 32'h0, 32'h8000_0000,
                      32'h0, 32'h0000_0100, 5'd12, 5'b10000, 2'b00, 32'h0800_0000, 4'b1001);
        checkOutput("srl4");

        $display("[TB] branch compare and one-cycle latency");
        applyStimulus("beq", 3'b001, 6'd0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                      32'h0, 32'h0000_0040, 5'd0, 5'b00001, 2'b00, 32'd0, 4'b0110);
        check32("beqEarly.branch", {31'd0, bus.branch_out}, 32'd0);
        check32("beqEarly.pc", bus.pc_out, 32'h0000_0100);
        checkOutput("beq");

        $display("[TB] add wrap and load path");
        applyStimulus("lw", 3'b000, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1,
                      32'hA5A5_A5A5, 32'h0, 5'd9, 5'b10110, 2'b10, 32'd0, 4'b0010);
        checkOutput("lw");
        applyStimulus("sw111", 3'b111, 6'd0, 5'd0, 32'd10, 32'd20,
                      32'h5A5A_5A5A, 32'h0000_0080, 5'd0, 5'b01000, 2'b00, 32'd30, 4'b0010);
        checkOutput("sw111");
        applyStimulus("slti", 3'b101, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd0,
                      32'h0, 32'h0, 5'd13, 5'b10000, 2'b11, 32'd1, 4'b0111);
        checkOutput("slti");
        applyStimulus("sltiu", 3'b110, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd0,
                      32'h0, 32'h0, 5'd14, 5'b10000, 2'b01, 32'd0, 4'b1010);
        checkOutput("sltiu");

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ex_alu_pipe.md
Name: ex_alu_pipe

Overview:
- Execute-stage datapath core of the 5-stage MIPS pipeline.
- Decodes the 3-bit ALUOp plus the instruction funct field into a 4-bit ALU control code.
- Performs the 32-bit ALU operation, producing a result and a zero flag.
- Captures result, flags, control bits and forwarded data into the EX/MEM pipeline register, which feeds the MEM stage.

Parameters:
- none (all widths fixed: 32-bit data, 5-bit register index)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears EX/MEM register
- alu_op  in  3  ALUOp from ID/EX
- funct  in  6  instruction bits [5:0]
- shamt  in  5  instruction bits [10:6]
- operand_a  in  32  rs read data
- operand_b  in  32  second ALU input (already muxed rt/immediate)
- rt_data  in  32  rt read data, forwarded as store data
- pc_in  in  32  computed branch target
- wb_dest_in  in  5  writeback register index (already muxed)
- RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, branch_in  in  1 each  control bits
- load_mode_in  in  2  load width/sign mode
- alu_ctrl  out  4  combinational ALU control code (observability)
- RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out, branch_out  out  1 each  registered
- load_mode_out  out  2  registered
- pc_out  out  32  registered
- zero_out  out  1  registered zero flag
- aluResult_out  out  32  registered ALU result
- rt_out  out  32  registered rt_data
- writebackDestination_out  out  5  registered

Behaviour:
ALU control (combinational), by alu_op:
- 000 ADD (lw/sw/addi)
- 001 SUB (beq/bne)
- 010 R-type, decoded from funct
- 011 AND (andi)
- 100 OR (ori)
- 101 SLT (slti)
- 110 SLTU (sltiu)
- 111 ADD

R-type funct decode:
- 100000 and 100001 -> ADD
- 100010 and 100011 -> SUB
- 100100 AND; 100101 OR; 100110 XOR; 100111 NOR
- 101010 SLT; 101011 SLTU
- 000000 SLL; 000010 SRL; 000011 SRA
- any other funct -> ADD

Control codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT
- 1000 SLL, 1001 SRL, 1010 SLTU, 1011 SRA, 1100 NOR
- any other code: result 0

ALU (combinational):
- ADD/SUB wrap modulo 2^32; no overflow trap, no overflow flag.
- SLT: signed compare a<b gives 32'd1, else 0. SLTU: same, unsigned.
- Shifts act on operand_b by shamt (0..31). SRA replicates bit 31. shamt=0 passes operand_b unchanged.
- zero = 1 iff the 32-bit result == 0.

EX/MEM register:
- On each rising clk edge, every *_out register loads its input: aluResult_out <= ALU result, zero_out <= zero, and all other inputs pass straight through.
- Latency exactly 1 cycle; no enable and no stall, so the register loads every cycle.
- reset high clears every registered output to 0 immediately, with no clock needed. It holds 0 while asserted.
- First capture occurs on the first rising edge after reset deasserts.
- alu_ctrl is never registered and ignores reset.

Test Plan:
- Reset mid-operation: load aluResult_out=0x1234, then assert reset between edges -> all outputs 0 before the next edge. Deassert, then clock once -> outputs track inputs.
- R-type decode: alu_op=010; funct=100010, a=5, b=7 -> aluResult_out=0xFFFFFFFE, zero_out=0. Funct=101010, same operands -> result 1. Funct=101011, a=0xFFFFFFFF, b=1 -> result 0.
- Shifts: alu_op=010, funct=000000, b=1, shamt=31 -> 0x80000000. funct=000011, b=0x80000000, shamt=4 -> 0xF8000000. funct=000010, same b and shamt -> 0x08000000.
- Branch compare: alu_op=001, a=b=0xDEADBEEF -> zero_out=1, result 0. Check branch_in=1, pc_in=0x40 appear as branch_out=1 and pc_out=0x40 one cycle later, not the same cycle.
- Add wrap and lw path: alu_op=000, a=0xFFFFFFFF, b=1 -> result 0, zero 1. MemRead_in=1, MemToReg_in=1, load_mode_in=2'b10, wb_dest_in=9, rt_data=0xA5A5A5A5 -> all mirrored after one edge.
- Unknown funct 111111 with alu_op=010 -> ADD (a=2, b=3 -> 5). ALU ops 011/100 with a=0xF0F0, b=0x0FF0 -> 0x00F0 and 0xFFF0.
